// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-style datapath control FSM
//
// Purpose: sequences FETCH/DECODE/execute/writeback for R-type, LW, SW,
// BEQ, ADDI, J and JAL, driving datapath enables and mux selects.
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   opcode[5:0]      IR[31:26], held stable by the IR after FETCH
//   mem_ready        memory finishes the current access this cycle
//   PCWRITE, BRANCH, IRWRITE, REGWRITE, MEMWRITE, mem_req   enables
//   ALUSRCA, ALUSRCB, ALUOP, PCSRC, WRITEDATASELECT, WRITEPORTSELECT  selects
//   state[3:0]       current state code
//   illegal_op       sticky unknown-opcode flag
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWRITE,
  output logic       BRANCH,
  output logic       IRWRITE,
  output logic       REGWRITE,
  output logic       MEMWRITE,
  output logic       mem_req,
  output logic       ALUSRCA,
  output logic [1:0] ALUSRCB,
  output logic [1:0] ALUOP,
  output logic [1:0] PCSRC,
  output logic [1:0] WRITEDATASELECT,
  output logic       WRITEPORTSELECT,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRCH   = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t r_state;
  logic   r_illegal_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_illegal_op <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      r_state <= S_EXEC;
            OP_LW, OP_SW:  r_state <= S_MEMADR;
            OP_BEQ:        r_state <= S_BRCH;
            OP_ADDI:       r_state <= S_ADDIEX;
            OP_J:          r_state <= S_JUMP;
            OP_JAL:        r_state <= S_JAL;
            default: begin
              r_state      <= S_FETCH;
              r_illegal_op <= 1'b1;
            end
          endcase
        end
        // Only LW/SW reach MEMADR; anything else falls back to FETCH.
        S_MEMADR: begin
          if (opcode == OP_LW)      r_state <= S_MEMRD;
          else if (opcode == OP_SW) r_state <= S_MEMWR;
          else                      r_state <= S_FETCH;
        end
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRCH:   r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        S_JAL:    r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  assign state      = r_state;
  assign illegal_op = r_illegal_op;

  always_comb begin
    PCWRITE         = 1'b0;
    BRANCH          = 1'b0;
    IRWRITE         = 1'b0;
    REGWRITE        = 1'b0;
    MEMWRITE        = 1'b0;
    mem_req         = 1'b0;
    ALUSRCA         = 1'b0;
    ALUSRCB         = 2'b00;
    ALUOP           = 2'b00;
    PCSRC           = 2'b00;
    WRITEDATASELECT = 2'b00;
    WRITEPORTSELECT = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSRCB = 2'b01;
        PCWRITE = mem_ready;
        IRWRITE = mem_ready;
      end
      S_DECODE: ALUSRCB = 2'b11;
      S_MEMADR: begin
        ALUSRCA = 1'b1;
        ALUSRCB = 2'b10;
      end
      S_MEMRD:  mem_req = 1'b1;
      S_MEMWB: begin
        REGWRITE        = 1'b1;
        WRITEDATASELECT = 2'b01;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MEMWRITE = 1'b1;
      end
      S_EXEC: begin
        ALUSRCA = 1'b1;
        ALUOP   = 2'b10;
      end
      S_ALUWB: begin
        REGWRITE        = 1'b1;
        WRITEPORTSELECT = 1'b1;
      end
      S_BRCH: begin
        ALUSRCA = 1'b1;
        ALUOP   = 2'b01;
        BRANCH  = 1'b1;
        PCSRC   = 2'b01;
      end
      S_ADDIEX: begin
        ALUSRCA = 1'b1;
        ALUSRCB = 2'b10;
      end
      S_ADDIWB: REGWRITE = 1'b1;
      S_JUMP: begin
        PCWRITE = 1'b1;
        PCSRC   = 2'b10;
      end
      S_JAL: begin
        PCWRITE         = 1'b1;
        PCSRC           = 2'b10;
        REGWRITE        = 1'b1;
        WRITEDATASELECT = 2'b10;
      end
      default: ;
    endcase
    // Reset kills every enable immediately, even mid-cycle (e.g. during a
    // MEMWR wait) since the state register alone would leave FETCH's mem_req.
    if (!reset) begin
      PCWRITE  = 1'b0;
      BRANCH   = 1'b0;
      IRWRITE  = 1'b0;
      REGWRITE = 1'b0;
      MEMWRITE = 1'b0;
      mem_req  = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL provide these ports, clock and reset first: clk input 1 (rising-edge clock); reset input 1 (asynchronous, active-low: asserted when 0).
REQ-002 The block SHALL provide these inputs: opcode input 6 (IR[31:26], sampled in DECODE); mem_ready input 1 (memory completes current access this cycle).
REQ-003 The block SHALL provide these write-enable outputs, all width 1: PCWRITE (unconditional PC load); BRANCH (PC load if ALU zero); IRWRITE (IR load); REGWRITE (register file write); MEMWRITE (data memory write); mem_req (memory access active).
REQ-004 The block SHALL provide these mux-select outputs: ALUSRCA 1 (0=PC, 1=A); ALUSRCB 2 (00=B, 01=const 4, 10=extendedIMM, 11=extendedIMM<<2); ALUOP 2 (00=add, 01=subtract, 10=funct-decoded); PCSRC 2 (00=ALU result, 01=ALUout, 10=jump target); WRITEDATASELECT 2 (00=ALUout, 01=MemData, 10=JALreturnPC; datapath forces port 31 for 10); WRITEPORTSELECT 1 (0=rt, 1=rd).
REQ-005 The block SHALL provide these status outputs: state output 4 (current state code); illegal_op output 1 (sticky unknown-opcode flag).

Function
REQ-006 The block SHALL be an FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JAL=12.
REQ-007 The block SHALL drive outputs combinationally from state and mem_ready; every output not listed for a state SHALL be 0.
REQ-008 FETCH SHALL drive mem_req=1, ALUSRCA=0, ALUSRCB=01, ALUOP=00, PCSRC=00, with PCWRITE=IRWRITE=mem_ready; it SHALL advance to DECODE only on mem_ready=1 and otherwise hold.
REQ-009 DECODE SHALL drive ALUSRCA=0, ALUSRCB=11, ALUOP=00, and SHALL branch on opcode: 000000->EXEC; 100011 or 101011->MEMADR; 000100->BRCH; 001000->ADDIEX; 000010->JUMP; 000011->JAL; other values->FETCH with illegal_op set to 1.
REQ-010 MEMADR SHALL drive ALUSRCA=1, ALUSRCB=10, ALUOP=00, then go to MEMRD for opcode 100011 or to MEMWR for opcode 101011.
REQ-011 MEMRD SHALL drive mem_req=1 and SHALL hold until mem_ready=1, then go to MEMWB.
REQ-012 MEMWB SHALL drive REGWRITE=1, WRITEDATASELECT=01, WRITEPORTSELECT=0, then go to FETCH.
REQ-013 MEMWR SHALL drive mem_req=1 and MEMWRITE=1 every cycle until mem_ready=1, then go to FETCH.
REQ-014 EXEC SHALL drive ALUSRCA=1, ALUSRCB=00, ALUOP=10, then go to ALUWB.
REQ-015 ALUWB SHALL drive REGWRITE=1, WRITEDATASELECT=00, WRITEPORTSELECT=1, then go to FETCH.
REQ-016 BRCH SHALL drive ALUSRCA=1, ALUSRCB=00, ALUOP=01, BRANCH=1, PCSRC=01, then go to FETCH.
REQ-017 ADDIEX SHALL drive ALUSRCA=1, ALUSRCB=10, ALUOP=00, then go to ADDIWB.
REQ-018 ADDIWB SHALL drive REGWRITE=1, WRITEDATASELECT=00, WRITEPORTSELECT=0, then go to FETCH.
REQ-019 JUMP SHALL drive PCWRITE=1 and PCSRC=10, then go to FETCH.
REQ-020 JAL SHALL drive PCWRITE=1, PCSRC=10, REGWRITE=1, WRITEDATASELECT=10, then go to FETCH.
REQ-021 The block SHALL have these latencies with mem_ready held 1: R-type/ADDI 4 cycles; LW 5; SW 4; BEQ/J/JAL 3; each wait cycle adds one.
REQ-022 The opcode used for branching in MEMADR SHALL be the opcode input, which the IR holds stable after FETCH.
REQ-023 Once set, illegal_op SHALL remain 1 until reset.
REQ-024 Unused state codes 13-15 SHALL go to FETCH on the next edge with all enables 0.

Reset
REQ-025 While reset=0, state SHALL be FETCH(0), illegal_op=0, and all enables (PCWRITE, IRWRITE, REGWRITE, MEMWRITE, BRANCH, mem_req) SHALL be forced to 0, regardless of clk.
REQ-026 Reset asserted mid-instruction, including during MEMWR wait, SHALL abort immediately with no further write enable.
REQ-027 After reset deasserts, the first rising edge SHALL evaluate FETCH.

Verification
REQ-028 Bench SHALL cover: reset low 5 cycles, release, mem_ready=1, opcode=000000 -> state 0,1,6,7,0; REGWRITE=1 only in state 7 with WRITEPORTSELECT=1.
REQ-029 Bench SHALL cover: opcode=100011, mem_ready=0 for 3 cycles in MEMRD -> state holds 3 for 3 cycles; MEMWB reached; LW total 8 cycles.
REQ-030 Bench SHALL cover: opcode=101011 with mem_ready low 2 cycles in MEMWR -> MEMWRITE=1 for exactly 3 cycles, then state 0.
REQ-031 Bench SHALL cover: opcode=000100 -> BRANCH=1, ALUOP=01, PCSRC=01 in state 8; opcode=000011 -> state 12 with PCWRITE=REGWRITE=1, WRITEDATASELECT=10.
REQ-032 Bench SHALL cover: opcode=111111 -> DECODE returns to FETCH, illegal_op=1 persists through subsequent valid instructions until reset.
REQ-033 Bench SHALL cover: reset pulsed low asynchronously mid-MEMWR -> MEMWRITE drops same instant, state=0.
